// File: rtl/sharpx1_pkg.sv
// Shared definitions for the Sharp X1 ioctl read-back path: region encoding,
// region sizes, host index codes and the upload engine state encoding.
package sharpx1_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_VRAM = 2'd1,
    REG_PCG  = 2'd2,
    REG_GRAM = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_FETCH = 2'd2,
    ST_READY = 2'd3
  } upl_state_e;

  localparam logic [16:0] SIZE_RAM  = 17'd65536;
  localparam logic [16:0] SIZE_VRAM = 17'd4096;
  localparam logic [16:0] SIZE_PCG  = 17'd6144;
  localparam logic [16:0] SIZE_GRAM = 17'd49152;

  localparam logic [7:0] IDX_RAM  = 8'h80;
  localparam logic [7:0] IDX_VRAM = 8'h81;
  localparam logic [7:0] IDX_PCG  = 8'h82;
  localparam logic [7:0] IDX_GRAM = 8'h83;

  localparam logic [16:0] PTR_SAT = 17'h1_0000;

  typedef struct packed {
    logic        valid;
    region_e     region;
    logic [16:0] limit;
  } region_info_t;

  // Unknown indices report a zero limit so every byte of them reads as pad.
  function automatic region_info_t decode_region(input logic [7:0] index);
    region_info_t info;
    info.valid  = 1'b1;
    info.region = REG_RAM;
    info.limit  = SIZE_RAM;
    case (index)
      IDX_RAM: info.limit = SIZE_RAM;
      IDX_VRAM: begin
        info.region = REG_VRAM;
        info.limit  = SIZE_VRAM;
      end
      IDX_PCG: begin
        info.region = REG_PCG;
        info.limit  = SIZE_PCG;
      end
      IDX_GRAM: begin
        info.region = REG_GRAM;
        info.limit  = SIZE_GRAM;
      end
      default: begin
        info.valid = 1'b0;
        info.limit = '0;
      end
    endcase
    return info;
  endfunction

endpackage

// File: rtl/sharpx1_rd_delay.sv
// Delays the memory read strobe by the memory read latency, producing the
// cycle in which mem_q carries the requested byte.
module sharpx1_rd_delay
  import sharpx1_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear,
  input  logic strobe,
  output logic valid
);

  logic [RD_LAT-1:0] sr_q;
  logic [RD_LAT-1:0] sr_d;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = strobe;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    if (clear) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid = sr_q[RD_LAT-1];

endmodule

// File: rtl/sharpx1_mem_upload.sv
// ioctl upload engine: streams one Sharp X1 memory region to the host a byte
// at a time, fetching each byte through the external region read mux.
module sharpx1_mem_upload
  import sharpx1_pkg::*;
#(
  parameter int         RD_LAT   = 2,
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_q,
  output logic        upl_err
);

  upl_state_e   state_q, state_d;
  region_e      region_q, region_d;
  logic         valid_q, valid_d;
  logic [16:0]  limit_q, limit_d;
  logic [16:0]  ptr_q, ptr_d;
  logic         rng_q, rng_d;
  logic         pending_q, pending_d;
  logic [7:0]   din_q, din_d;
  logic         wait_q, wait_d;
  logic [15:0]  mem_addr_q, mem_addr_d;
  logic         mem_rd_q, mem_rd_d;
  logic         err_q, err_d;
  logic         upload_prev_q;

  region_info_t info;
  logic [16:0]  ptr_inc;
  logic         data_valid;
  logic         loaded;
  logic         enter_fetch;
  logic [16:0]  fetch_ptr;
  logic         fetch_valid;
  logic [16:0]  fetch_limit;
  logic         fetch_rng;

  assign info    = decode_region(ioctl_index);
  assign ptr_inc = (ptr_q == PTR_SAT) ? ptr_q : ptr_q + 17'd1;
  assign loaded  = (state_q == ST_FETCH) && (rng_q ? data_valid : 1'b1);

  // Dropping ioctl_upload flushes the latency pipe so a late mem_q is never taken.
  sharpx1_rd_delay #(
    .RD_LAT (RD_LAT)
  ) u_rd_delay (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (!ioctl_upload),
    .strobe  (mem_rd_q),
    .valid   (data_valid)
  );

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    valid_d     = valid_q;
    limit_d     = limit_q;
    ptr_d       = ptr_q;
    rng_d       = rng_q;
    pending_d   = pending_q;
    din_d       = din_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    err_d       = err_q;
    enter_fetch = 1'b0;
    fetch_ptr   = ptr_q;
    fetch_valid = valid_q;
    fetch_limit = limit_q;
    fetch_rng   = 1'b0;

    if (!ioctl_upload) begin
      state_d   = ST_IDLE;
      wait_d    = 1'b0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!upload_prev_q) begin
            state_d = ST_START;
            wait_d  = 1'b1;
          end
        end
        ST_START: begin
          region_d    = info.region;
          valid_d     = info.valid;
          limit_d     = info.limit;
          ptr_d       = '0;
          err_d       = 1'b0;
          pending_d   = 1'b0;
          enter_fetch = 1'b1;
          fetch_ptr   = '0;
          fetch_valid = info.valid;
          fetch_limit = info.limit;
        end
        ST_FETCH: begin
          if (ioctl_rd) begin
            err_d = 1'b1;
          end
          // A request that arrived while fetching chains straight into the next byte.
          if (loaded) begin
            din_d = rng_q ? mem_q : PAD_BYTE;
            if (pending_q || ioctl_rd) begin
              pending_d   = 1'b0;
              ptr_d       = ptr_inc;
              enter_fetch = 1'b1;
              fetch_ptr   = ptr_inc;
            end else begin
              wait_d  = 1'b0;
              state_d = ST_READY;
            end
          end else if (ioctl_rd) begin
            pending_d = 1'b1;
          end
        end
        ST_READY: begin
          if (ioctl_rd) begin
            ptr_d       = ptr_inc;
            enter_fetch = 1'b1;
            fetch_ptr   = ptr_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (enter_fetch) begin
        fetch_rng = fetch_valid && (fetch_ptr < fetch_limit);
        state_d   = ST_FETCH;
        wait_d    = 1'b1;
        rng_d     = fetch_rng;
        mem_rd_d  = fetch_rng;
        if (fetch_rng) begin
          mem_addr_d = fetch_ptr[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      region_q      <= REG_RAM;
      valid_q       <= 1'b0;
      limit_q       <= '0;
      ptr_q         <= '0;
      rng_q         <= 1'b0;
      pending_q     <= 1'b0;
      din_q         <= PAD_BYTE;
      wait_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      err_q         <= 1'b0;
      upload_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      region_q      <= region_d;
      valid_q       <= valid_d;
      limit_q       <= limit_d;
      ptr_q         <= ptr_d;
      rng_q         <= rng_d;
      pending_q     <= pending_d;
      din_q         <= din_d;
      wait_q        <= wait_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      err_q         <= err_d;
      upload_prev_q <= ioctl_upload;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_sel    = region_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign upl_err    = err_q;

endmodule

// File: tb/tb_sharpx1_mem_upload.sv
// Self-checking bench for sharpx1_mem_upload: a byte-stream model of the host
// session checked every ready cycle, plus directed scenarios with literal values.
module tb_sharpx1_mem_upload;

  localparam int         RD_LAT = 2;
  localparam logic [7:0] PAD    = 8'hFF;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic        upl_err;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  sharpx1_mem_upload #(
    .RD_LAT   (RD_LAT),
    .PAD_BYTE (PAD)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_q        (mem_q),
    .upl_err      (upl_err)
  );

  // Memory contents per region; RAM follows i ^ 0x5A.
  function automatic logic [7:0] memByte(input logic [1:0] sel, input logic [15:0] a);
    case (sel)
      2'd0:    return a[7:0] ^ 8'h5A;
      2'd1:    return a[7:0] ^ 8'hC3 ^ a[15:8];
      2'd2:    return a[7:0] + 8'h11;
      default: return a[7:0] ^ 8'hF0 ^ a[15:8];
    endcase
  endfunction

  function automatic int regionLimit(input logic [7:0] idx);
    case (idx)
      8'h80:   return 65536;
      8'h81:   return 4096;
      8'h82:   return 6144;
      8'h83:   return 49152;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] expByte(input logic [7:0] idx, input int n);
    if (n < regionLimit(idx)) return memByte(idx[1:0], n[15:0]);
    return PAD;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory with RD_LAT latency; returns noise on cycles without a fresh read.
  logic [7:0] mem_pipe [RD_LAT];
  int cyc = 0;
  int mem_rd_count = 0;
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rd_count <= mem_rd_count + 1;
    mem_pipe[0] <= mem_rd ? memByte(mem_sel, mem_addr) : (8'(cyc) ^ 8'h3C);
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_q = mem_pipe[RD_LAT-1];

  // Host-level model: byte n of a session is the region byte n after n requests.
  logic       m_prev = 1'b0;
  logic       m_in_session = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_idx = 8'h00;
  int         m_count = 0;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_prev       <= 1'b0;
      m_in_session <= 1'b0;
      m_err        <= 1'b0;
      m_count      <= 0;
    end else begin
      m_prev <= ioctl_upload;
      if (!ioctl_upload) begin
        m_in_session <= 1'b0;
      end else if (!m_prev && !m_in_session) begin
        m_in_session <= 1'b1;
        m_idx        <= ioctl_index;
        m_count      <= 0;
        m_err        <= 1'b0;
      end else if (m_in_session && ioctl_rd) begin
        if (ioctl_wait) m_err <= 1'b1;
        if (m_count < 65536) m_count <= m_count + 1;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (m_in_session) begin
        if (!ioctl_wait) begin
          checkOutput("model_din", ioctl_din, expByte(m_idx, m_count));
          checkOutput("model_err", upl_err, m_err);
          if (regionLimit(m_idx) != 0) checkOutput("model_sel", mem_sel, m_idx[1:0]);
        end
        if (mem_rd) begin
          checkOutput("mem_rd_addr_in_limit", int'(mem_addr) < regionLimit(m_idx), 1);
          checkOutput("mem_rd_sel", mem_sel, m_idx[1:0]);
          checkOutput("mem_rd_while_wait", ioctl_wait, 1);
        end
      end else begin
        checkOutput("mem_rd_outside_session", mem_rd, 0);
      end
    end
  end

  task automatic applyStimulus(input logic upload, input logic [7:0] idx, input logic rd);
    @(negedge clk_sys);
    ioctl_upload = upload;
    ioctl_index  = idx;
    ioctl_rd     = rd;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    @(negedge clk_sys);
    while (ioctl_wait && n < 64) begin
      n++;
      @(negedge clk_sys);
    end
    checkOutput(name, ioctl_wait, 0);
  endtask

  task automatic startSession(input logic [7:0] idx);
    applyStimulus(1'b1, idx, 1'b0);
    waitReady("session_start_ready");
  endtask

  task automatic readByte(output int wait_cycles);
    applyStimulus(1'b1, ioctl_index, 1'b1);
    applyStimulus(1'b1, ioctl_index, 1'b0);
    wait_cycles = 0;
    while (ioctl_wait && wait_cycles < 64) begin
      wait_cycles++;
      @(negedge clk_sys);
    end
    if (ioctl_wait) checkOutput("read_timeout", ioctl_wait, 0);
  endtask

  initial begin
    int wc;
    int rd_before;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    checkOutput("reset_din", ioctl_din, 8'hFF);
    checkOutput("reset_wait", ioctl_wait, 0);
    checkOutput("reset_sel", mem_sel, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_rd", mem_rd, 0);
    checkOutput("reset_err", upl_err, 0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // RAM stream, latency per byte and index change ignored mid-session
    startSession(8'h80);
    checkOutput("ram_byte0", ioctl_din, 8'h5A);
    readByte(wc);
    checkOutput("ram_byte1", ioctl_din, 8'h5B);
    checkOutput("ram_wait_cycles", wc, 3);
    for (int k = 2; k <= 16; k++) begin
      if (k == 8) ioctl_index = 8'h83;
      readByte(wc);
      checkOutput("ram_wait_cycles", wc, 3);
    end
    checkOutput("ram_byte16", ioctl_din, 8'h4A);

    // Second request during FETCH: error, pending chain, READY shows ptr+2
    applyStimulus(1'b1, ioctl_index, 1'b1);
    applyStimulus(1'b1, ioctl_index, 1'b1);
    checkOutput("pend_first_rd", mem_rd, 1);
    applyStimulus(1'b1, ioctl_index, 1'b0);
    repeat (2) @(negedge clk_sys);
    checkOutput("pend_mid_din", ioctl_din, 8'h4B);
    checkOutput("pend_mid_wait", ioctl_wait, 1);
    checkOutput("pend_refetch_addr", mem_addr, 16'd18);
    checkOutput("pend_err", upl_err, 1);
    waitReady("pend_ready");
    checkOutput("pend_byte18", ioctl_din, 8'h48);
    applyStimulus(1'b0, 8'h80, 1'b0);
    repeat (3) @(negedge clk_sys);

    // VRAM end of region
    startSession(8'h81);
    checkOutput("vram_err_cleared", upl_err, 0);
    for (int k = 1; k <= 4100; k++) begin
      readByte(wc);
      if (k == 4095) checkOutput("vram_byte4095", ioctl_din, 8'h33);
      if (k == 4096) checkOutput("vram_byte4096", ioctl_din, 8'hFF);
      if (k == 4096) checkOutput("vram_pad_wait", wc, 1);
    end
    checkOutput("vram_byte4099", ioctl_din, 8'hFF);
    applyStimulus(1'b0, 8'h81, 1'b0);
    repeat (3) @(negedge clk_sys);

    // Unknown index: pad only, no memory traffic
    rd_before = mem_rd_count;
    startSession(8'h42);
    checkOutput("bad_byte0", ioctl_din, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      readByte(wc);
      checkOutput("bad_wait_cycles", wc, 1);
      checkOutput("bad_byte", ioctl_din, 8'hFF);
    end
    checkOutput("bad_no_mem_rd", mem_rd_count - rd_before, 0);
    applyStimulus(1'b0, 8'h42, 1'b0);
    repeat (3) @(negedge clk_sys);

    // Abort one cycle after mem_rd
    startSession(8'h80);
    readByte(wc);
    readByte(wc);
    checkOutput("abort_pre_din", ioctl_din, 8'h58);
    applyStimulus(1'b1, 8'h80, 1'b1);
    applyStimulus(1'b1, 8'h80, 1'b0);
    checkOutput("abort_mem_rd", mem_rd, 1);
    checkOutput("abort_mem_addr", mem_addr, 16'd3);
    applyStimulus(1'b0, 8'h80, 1'b0);
    @(negedge clk_sys);
    checkOutput("abort_wait", ioctl_wait, 0);
    checkOutput("abort_din", ioctl_din, 8'h58);
    repeat (2) @(negedge clk_sys);
    checkOutput("abort_late_din", ioctl_din, 8'h58);

    // Async reset mid-FETCH, then a fresh PCG session
    startSession(8'h83);
    checkOutput("gram_byte0", ioctl_din, 8'hF0);
    readByte(wc);
    checkOutput("gram_byte1", ioctl_din, 8'hF1);
    applyStimulus(1'b1, 8'h83, 1'b1);
    @(negedge clk_sys);
    checkOutput("gram_mem_rd", mem_rd, 1);
    #2;
    reset_n = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    #1;
    checkOutput("areset_din", ioctl_din, 8'hFF);
    checkOutput("areset_wait", ioctl_wait, 0);
    checkOutput("areset_sel", mem_sel, 0);
    checkOutput("areset_addr", mem_addr, 0);
    checkOutput("areset_rd", mem_rd, 0);
    checkOutput("areset_err", upl_err, 0);
    repeat (2) @(negedge clk_sys);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      checkOutput("post_reset_rd", mem_rd, 0);
    end
    applyStimulus(1'b1, 8'h82, 1'b0);
    repeat (2) @(negedge clk_sys);
    checkOutput("pcg_first_rd", mem_rd, 1);
    checkOutput("pcg_first_addr", mem_addr, 0);
    checkOutput("pcg_sel", mem_sel, 2);
    waitReady("pcg_ready");
    checkOutput("pcg_byte0", ioctl_din, 8'h11);
    readByte(wc);
    checkOutput("pcg_byte1", ioctl_din, 8'h12);
    applyStimulus(1'b0, 8'h82, 1'b0);
    repeat (3) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
